uart_host_ctrl: RTL

- Host-side controller for the UART CPU port. Drives `rdn` toward the receiver and `wrn`/`d_in` toward the transmitter.
- Turns the UART's active-low strobe handshakes into two valid/ready byte streams for on-chip logic.
- Each direction is buffered by a small FIFO.
- Sits between the UART receiver/transmitter pair and the user/bus logic, clocked on the same 16x baud clock.

---
 rtl/uart_host_pkg.sv | 33 +++
 rtl/uart_host_fifo.sv | 52 +++++
 rtl/uart_host_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_pkg.sv
// Shared types and default parameters for the UART host controller.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
// Contents: RX/TX FSM state enums, the RX FIFO entry layout and the default
//   values of DEPTH, WR_LOW and ACK_TMO.
package uart_host_pkg;

  localparam int DEF_DEPTH   = 4;   // entries per FIFO, power of 2, >= 2
  localparam int DEF_WR_LOW  = 2;   // cycles wrn is held low per write
  localparam int DEF_ACK_TMO = 15;  // strobe acknowledge timeout, 1..255

  // Both enums live in one package, so the state names carry a prefix.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_STROBE,
    RX_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_LOW,
    TX_HOLD,
    TX_WAIT
  } tx_state_t;

  // One RX FIFO entry: err = {frame_error, parity_error}, captured with the byte.
  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_host_fifo.sv
// Small synchronous FIFO with a combinational head output.
// Latency: a pushed entry is visible at the head one cycle later (no write-through).
// Backpressure: push is ignored when full unless a pop happens in the same cycle;
//   pop is ignored when empty.
// Ports: clk, clr (sync, active high), push/push_dat, pop, head, full, empty.
import uart_host_pkg::*;

module uart_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit: equal low bits with differing MSBs means full.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side controller for the UART CPU port: strobe handshakes <-> valid/ready byte streams.
// Latency: r_ready rise to rdn low 1 cycle, rdn low to rx_valid 1 cycle; tx byte to wrn low 3 cycles.
// Backpressure: rx waits (never drops) while its FIFO is full; tx_ready = tx FIFO not full.
// Ports: clk16x/clr; UART side rdn, d_out, r_ready, parity_error, frame_error, d_in, wrn,
//   t_empty, sending; stream side rx_valid/rx_data/rx_err/rx_ready, tx_valid/tx_data/tx_ready;
//   status tx_busy, ovf (sticky), ack_err (sticky).
import uart_host_pkg::*;

module uart_host_ctrl #(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int WR_LOW  = DEF_WR_LOW,
  parameter int ACK_TMO = DEF_ACK_TMO
) (
  input  logic       clk16x,
  input  logic       clr,
  output logic       rdn,
  input  logic [7:0] d_out,
  input  logic       r_ready,
  input  logic       parity_error,
  input  logic       frame_error,
  output logic [7:0] d_in,
  output logic       wrn,
  input  logic       t_empty,
  input  logic       sending,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_err,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       ovf,
  output logic       ack_err
);

  // One counter width covers the write-low count and the timeout count.
  localparam int CMAX = (WR_LOW > ACK_TMO) ? WR_LOW : ACK_TMO;
  localparam int CW   = $clog2(CMAX + 1);

  rx_state_t      rx_st;
  tx_state_t      tx_st;
  logic [CW-1:0]  rx_cnt;
  logic [CW-1:0]  tx_cnt;
  logic           rx_ack_err;
  logic           tx_ack_err;

  rx_entry_t      rx_in;
  rx_entry_t      rx_head;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;

  logic [7:0]     tx_head;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;

  // ---------------- RX path ----------------
  // The byte is captured on the edge that ends the one-cycle rdn pulse.
  assign rx_in.err  = {frame_error, parity_error};
  assign rx_in.data = d_out;
  assign rx_push    = (rx_st == RX_STROBE);
  assign rx_pop     = rx_valid && rx_ready;
  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_head.data;
  assign rx_err     = rx_head.err;

  uart_host_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk      (clk16x),
    .clr      (clr),
    .push     (rx_push),
    .push_dat (rx_in),
    .pop      (rx_pop),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  always_ff @(posedge clk16x) begin
    if (clr) begin
      rx_st      <= RX_IDLE;
      rdn        <= 1'b1;
      rx_cnt     <= '0;
      ovf        <= 1'b0;
      rx_ack_err <= 1'b0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          if (r_ready && !rx_full) begin
            rdn    <= 1'b0;
            rx_st  <= RX_STROBE;
            rx_cnt <= '0;
          end else if (r_ready) begin
            // Byte pending but nowhere to put it: keep waiting, flag after ACK_TMO+1 cycles.
            if (rx_cnt == CW'(ACK_TMO)) ovf <= 1'b1;
            else                        rx_cnt <= rx_cnt + CW'(1);
          end else begin
            rx_cnt <= '0;
          end
        end
        RX_STROBE: begin
          rdn    <= 1'b1;
          rx_st  <= RX_WAIT;
          rx_cnt <= '0;
        end
        RX_WAIT: begin
          // Only return to IDLE once r_ready drops, so one byte is never read twice.
          if (!r_ready) begin
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
          end else if (rx_cnt == CW'(ACK_TMO - 1)) begin
            rx_ack_err <= 1'b1;
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX path ----------------
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_pop   = (tx_st == TX_IDLE) && !tx_empty && t_empty;
  assign tx_busy  = !tx_empty || (tx_st != TX_IDLE) || sending;
  assign ack_err  = rx_ack_err || tx_ack_err;

  uart_host_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk      (clk16x),
    .clr      (clr),
    .push     (tx_push),
    .push_dat (tx_data),
    .pop      (tx_pop),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  always_ff @(posedge clk16x) begin
    if (clr) begin
      tx_st      <= TX_IDLE;
      wrn        <= 1'b1;
      d_in       <= '0;
      tx_cnt     <= '0;
      tx_ack_err <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          // d_in keeps the last written byte until the next pop.
          if (tx_pop) begin
            d_in  <= tx_head;
            tx_st <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          wrn    <= 1'b0;
          tx_st  <= TX_LOW;
          tx_cnt <= '0;
        end
        TX_LOW: begin
          if (tx_cnt == CW'(WR_LOW - 1)) begin
            wrn   <= 1'b1;
            tx_st <= TX_HOLD;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_HOLD: begin
          tx_st  <= TX_WAIT;
          tx_cnt <= '0;
        end
        TX_WAIT: begin
          // The transmitter acknowledges by dropping t_empty.
          if (!t_empty) begin
            tx_st <= TX_IDLE;
          end else if (tx_cnt == CW'(ACK_TMO - 1)) begin
            tx_ack_err <= 1'b1;
            tx_st      <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule
